// File: rtl/ram_frame_reader_if.sv
// Output stream bundle of ram_frame_reader: data beats with row/frame end markers.
// A beat transfers on a rising clk edge where m_valid && m_ready; master holds beat stable until then.
interface ram_frame_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last_col;
    logic                  m_last_row;

    modport master (
        output m_data, m_valid, m_last_col, m_last_row,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_last_col, m_last_row,
        output m_ready
    );
endinterface

// File: rtl/ram_frame_reader.sv
// Scans a block of RAM rows through the read port and streams the words out with markers.
// Optional macro RAM_FRAME_READER_LOOP_EN adds a loop input that repeats the frame until abort.
module ram_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(ROWS)-1:0]    start_row,
    input  logic [$clog2(ROWS+1)-1:0]  row_count,
`ifdef RAM_FRAME_READER_LOOP_EN
    input  logic                       loop,
`endif
    input  logic                       abort,
    output logic [$clog2(ROWS)-1:0]    r_row,
    output logic [$clog2(COLS)-1:0]    r_col,
    input  logic [DATA_WIDTH-1:0]      ram_dout,
    ram_frame_reader_if.master         m,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 state_dbg
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [RW-1:0]         start_row_q;
    logic [NW-1:0]         row_cnt_q, row_idx;
    logic                  loop_q, loop_in;
    logic                  rd_pend, pend_lc, pend_lr;
    logic [DATA_WIDTH+1:0] fifo_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt, occ;
    logic                  push, pop, issue, col_end, row_end, frame_end, launch;

`ifdef RAM_FRAME_READER_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign m.m_valid = (fifo_cnt != 2'd0);
    assign {m.m_last_col, m.m_last_row, m.m_data} = fifo_mem[rd_ptr];

    assign push      = rd_pend;
    assign pop       = m.m_valid && m.m_ready;
    // Buffered plus in-flight words after this cycle's pop; a new read only fits below 2.
    assign occ       = fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign col_end   = (r_col == CW'(COLS - 1));
    assign row_end   = (row_idx == row_cnt_q - NW'(1));
    assign frame_end = col_end && row_end;
    assign issue     = (state == ISSUE) && !abort && !occ[1];
    assign launch    = (state == IDLE) && start && !abort;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = (row_count == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (abort)                             state_nxt = IDLE;
                else if (issue && frame_end && !loop_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)                                state_nxt = IDLE;
                else if (fifo_cnt == 2'd0 && !rd_pend)    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            start_row_q <= '0;
            row_cnt_q   <= '0;
            row_idx     <= '0;
            loop_q      <= 1'b0;
            rd_pend     <= 1'b0;
            pend_lc     <= 1'b0;
            pend_lr     <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            // Abort drops the buffered beats and the read whose data is still on ram_dout.
            if (abort && state != IDLE) begin
                rd_pend  <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                fifo_cnt <= 2'd0;
            end else begin
                rd_pend <= issue;
                pend_lc <= col_end;
                pend_lr <= row_end;
                if (push) begin
                    fifo_mem[wr_ptr] <= {pend_lc, pend_lr, ram_dout};
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            end

            if (launch && row_count != '0) begin
                r_row       <= start_row;
                r_col       <= '0;
                start_row_q <= start_row;
                row_cnt_q   <= row_count;
                row_idx     <= '0;
                loop_q      <= loop_in;
            end else if (issue) begin
                if (col_end) begin
                    r_col <= '0;
                    if (frame_end && loop_q) begin
                        r_row   <= start_row_q;
                        row_idx <= '0;
                    end else begin
                        r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
                        row_idx <= row_idx + NW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_frame_reader.sv
// Self-checking bench for ram_frame_reader: RAM model, stream collector, reference frame model.
module tb_ram_frame_reader;
    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int COLS = 32;
    localparam int W    = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [1:0]    start_row;
    logic [2:0]    row_count;
`ifdef RAM_FRAME_READER_LOOP_EN
    logic          loop;
`endif
    logic [1:0]    r_row;
    logic [4:0]    r_col;
    logic [DW-1:0] ram_dout;
    logic          busy, done;
    logic [1:0]    state_dbg;
    logic [DW-1:0] mem [ROWS][COLS];

    ram_frame_reader_if #(.DATA_WIDTH(DW)) sif ();

    ram_frame_reader #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_row(start_row),
        .row_count(row_count),
`ifdef RAM_FRAME_READER_LOOP_EN
        .loop(loop),
`endif
        .abort(abort), .r_row(r_row), .r_col(r_col), .ram_dout(ram_dout),
        .m(sif), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / RAM with one-cycle registered read
    always #5 clk = ~clk;
    always @(posedge clk) ram_dout <= mem[r_row][r_col];

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    int got_first, got_last, first_valid, done_cnt, done_iter, valid_cycles;
    int max_occ, stab_err, post_abort_valid, post_abort_busy;
    bit timed_out;

    task automatic cyc;
        @(posedge clk); #1;
    endtask

    // Reference frame: row-major words mem[r][c] = r*COLS + c, markers from frame geometry.
    task automatic build_exp(input int sr, input int rc, input int reps);
        logic lr, lc;
        logic [DW-1:0] d;
        int row;
        exp_q.delete();
        for (int f = 0; f < reps; f++)
            for (int i = 0; i < rc; i++)
                for (int c = 0; c < COLS; c++) begin
                    row = (sr + i) % ROWS;
                    lr  = (i == rc - 1);
                    lc  = (c == COLS - 1);
                    d   = DW'(row * COLS + c);
                    exp_q.push_back({lr, lc, d});
                end
    endtask

    task automatic do_start(input int sr, input int rc, input bit lp);
        start     = 1'b1;
        start_row = 2'(sr);
        row_count = 3'(rc);
`ifdef RAM_FRAME_READER_LOOP_EN
        loop      = lp;
`else
        if (lp) $display("note: loop requested in a build without loop support");
`endif
        cyc();
        start = 1'b0;
    endtask

    // Drives m_ready (mode 0: always, 1: random with a 10-cycle stall) and records stream activity.
    task automatic collect(input int mode, input int abort_at, input int spur_at, input int budget);
        logic [W-1:0] cur, prev;
        logic [6:0] prev_addr;
        bit prev_stall = 0, aborted = 0, finished = 0;
        int issued = 0, occ, abort_iter = -10, tail = -1;
        got_q.delete();
        got_first = -1; got_last = -1; first_valid = -1; done_cnt = 0; done_iter = -1;
        valid_cycles = 0; max_occ = 0; stab_err = 0; post_abort_valid = -1; post_abort_busy = -1;
        timed_out = 0;
        prev = '0;
        prev_addr = {r_row, r_col};
        for (int it = 0; it < budget; it++) begin
            start = 1'b0;
            abort = 1'b0;
            if (mode == 0) sif.m_ready = 1'b1;
            else sif.m_ready = (it >= 20 && it < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (abort_at >= 0 && !aborted && got_q.size() == abort_at) begin
                abort = 1'b1; sif.m_ready = 1'b0; aborted = 1; abort_iter = it;
            end
            if (it == spur_at) begin
                start = 1'b1; start_row = 2'($urandom_range(0, 3)); row_count = 3'd1;
            end
            @(negedge clk);
            cur = {sif.m_last_row, sif.m_last_col, sif.m_data};
            if ({r_row, r_col} != prev_addr) issued++;
            prev_addr = {r_row, r_col};
            occ = issued - got_q.size();
            if (occ > max_occ) max_occ = occ;
            if (sif.m_valid) valid_cycles++;
            if (sif.m_valid && first_valid < 0) first_valid = it;
            if (prev_stall && it != abort_iter + 1 && (!sif.m_valid || cur !== prev)) stab_err++;
            if (done) begin done_cnt++; done_iter = it; end
            if (aborted && it == abort_iter + 1) begin
                post_abort_valid = int'(sif.m_valid); post_abort_busy = int'(busy);
            end
            if (sif.m_valid && sif.m_ready) begin
                got_q.push_back(cur);
                if (got_first < 0) got_first = it;
                got_last = it;
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev = cur;
            if (tail < 0 && done) tail = it + 3;
            if (tail < 0 && aborted && it > abort_iter + 1) tail = it + 5;
            if (it == tail) finished = 1;
            @(posedge clk); #1;
            if (finished) break;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!finished) timed_out = 1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sif.m_ready = 1'b0;
        start_row = '0; row_count = '0;
`ifdef RAM_FRAME_READER_LOOP_EN
        loop = 1'b0;
`endif
        cyc(); cyc();
    endtask

    task automatic test_reset;
        apply_reset();
        vectors++; if (sif.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", sif.m_valid); end
        vectors++; if (sif.m_data !== '0) begin miscompares++; $display("FAIL reset_data got=%0d exp=0", sif.m_data); end
        vectors++; if ({sif.m_last_col, sif.m_last_row} !== 2'b00) begin miscompares++; $display("FAIL reset_markers got=%b exp=00", {sif.m_last_col, sif.m_last_row}); end
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
        vectors++; if ({r_row, r_col} !== 7'd0) begin miscompares++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", r_row, r_col); end
        vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic_frame;
        build_exp(1, 2, 1);
        do_start(1, 2, 0);
        collect(0, -1, -1, 200);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout got=1 exp=0"); end
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        vectors++; if (first_valid !== 2) begin miscompares++; $display("FAIL basic_latency got=%0d exp=2", first_valid); end
        vectors++; if (got_last - got_first !== 63) begin miscompares++; $display("FAIL basic_no_bubble got=%0d exp=63", got_last - got_first); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        vectors++; if (max_occ > 2) begin miscompares++; $display("FAIL basic_occupancy got=%0d exp<=2", max_occ); end
    endtask

    task automatic test_row_wrap;
        build_exp(3, 2, 1);
        do_start(3, 2, 0);
        collect(0, -1, -1, 200);
        vectors++; if (got_q.size() !== exp_q.size() || timed_out) begin miscompares++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL wrap_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL wrap_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure;
        for (int n = 0; n < 4; n++) begin
            int sr, rc;
            sr = (n == 0) ? 1 : int'($urandom_range(0, 3));
            rc = (n == 0) ? 2 : int'($urandom_range(1, 4));
            build_exp(sr, rc, 1);
            do_start(sr, rc, 0);
            collect(1, -1, (n == 0) ? -1 : 40, 800);
            vectors++; if (got_q.size() !== exp_q.size() || timed_out) begin miscompares++; $display("FAIL bp%0d_count got=%0d exp=%0d", n, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL bp%0d_beat[%0d] got=%h exp=%h", n, i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
                end
            end
            vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL bp%0d_stable got=%0d exp=0", n, stab_err); end
            vectors++; if (max_occ > 2) begin miscompares++; $display("FAIL bp%0d_occupancy got=%0d exp<=2", n, max_occ); end
            vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL bp%0d_done_cnt got=%0d exp=1", n, done_cnt); end
        end
    endtask

    task automatic test_zero_rows;
        logic [6:0] addr_before;
        addr_before = {r_row, r_col};
        do_start(0, 0, 0);
        collect(0, -1, -1, 20);
        vectors++; if (done_iter !== 0 || done_cnt !== 1) begin miscompares++; $display("FAIL zero_done got=%0d@%0d exp=1@0", done_cnt, done_iter); end
        vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL zero_valid got=%0d exp=0", valid_cycles); end
        vectors++; if ({r_row, r_col} !== addr_before) begin miscompares++; $display("FAIL zero_addr got=%0d exp=%0d", {r_row, r_col}, addr_before); end
    endtask

    task automatic test_abort;
        build_exp(0, 4, 1);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        do_start(0, 4, 0);
        collect(0, 10, -1, 100);
        vectors++; if (got_q.size() !== 10 || timed_out) begin miscompares++; $display("FAIL abort_count got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL abort_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        vectors++; if (post_abort_valid !== 0 || post_abort_busy !== 0) begin miscompares++; $display("FAIL abort_next_cycle got=v%0d b%0d exp=v0 b0", post_abort_valid, post_abort_busy); end
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        build_exp(0, 1, 1);
        do_start(0, 1, 0);
        collect(0, -1, -1, 100);
        vectors++; if (got_q.size() !== 32 || timed_out) begin miscompares++; $display("FAIL after_abort_count got=%0d exp=32", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL after_abort_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_start_abort_same_cycle;
        start = 1'b1; abort = 1'b1; start_row = 2'd0; row_count = 3'd2;
        cyc();
        start = 1'b0; abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_abort_busy got=%b exp=0", busy); end
        cyc(); cyc(); cyc();
        vectors++; if (sif.m_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL start_abort_idle got=v%b d%b exp=v0 d0", sif.m_valid, done); end
    endtask

    task automatic test_reset_mid_frame;
        sif.m_ready = 1'b0;
        do_start(2, 3, 0);
        for (int i = 0; i < 8; i++) cyc();
        rst_n = 1'b0;
        cyc();
        vectors++; if ({sif.m_valid, busy, done} !== 3'b000) begin miscompares++; $display("FAIL midreset_flags got=%b exp=000", {sif.m_valid, busy, done}); end
        vectors++; if ({r_row, r_col} !== 7'd0 || sif.m_data !== '0) begin miscompares++; $display("FAIL midreset_clear got=%0d/%0d/%0d exp=0/0/0", r_row, r_col, sif.m_data); end
        rst_n = 1'b1;
        cyc();
    endtask

`ifdef RAM_FRAME_READER_LOOP_EN
    task automatic test_loop;
        build_exp(0, 1, 3);
        do_start(0, 1, 1);
        collect(0, 96, -1, 200);
        vectors++; if (got_q.size() !== 96 || timed_out) begin miscompares++; $display("FAIL loop_count got=%0d exp=96", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL loop_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        vectors++; if (got_last - got_first !== 95) begin miscompares++; $display("FAIL loop_no_gap got=%0d exp=95", got_last - got_first); end
        vectors++; if (done_cnt !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL loop_abort got=d%0d b%b exp=d0 b0", done_cnt, busy); end
        loop = 1'b0;
    endtask
`endif

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[r][c] = DW'(r * COLS + c);
        test_reset();
        test_basic_frame();
        test_row_wrap();
        test_backpressure();
        test_zero_rows();
        test_abort();
        test_start_abort_same_cycle();
`ifdef RAM_FRAME_READER_LOOP_EN
        test_loop();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
